// File: rtl/cluster_centroid_pkg.sv
// Shared definitions for the K-means centroid engine: FSM encoding and
// default geometry constants.
package cluster_centroid_pkg;

  localparam int DEF_NUM_CLUSTERS = 8;
  localparam int DEF_COORD_W      = 9;
  localparam int DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

endpackage

// File: rtl/cluster_centroid_engine_divider.sv
// Unsigned serial restoring divider: one quotient bit per cycle, DVD_W cycles
// after the load edge. o_done flags the cycle whose edge retires the last bit.
module center_divider
  import cluster_centroid_pkg::*;
#(
  parameter int DVD_W = DEF_COORD_W + DEF_CNT_W,
  parameter int DVS_W = DEF_CNT_W,
  parameter int Q_W   = DEF_COORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [Q_W-1:0]   o_quot
);

  localparam int ITER_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0]  r_quo;
  logic [DVS_W-1:0]  r_rem;
  logic [DVS_W-1:0]  r_dvs;
  logic [ITER_W-1:0] r_iter;
  logic              r_busy;
  logic [DVS_W:0]    w_rem_sh;
  logic [DVS_W:0]    w_diff;

  // Partial remainder stays below the divisor, so one extra bit suffices for the trial subtract.
  assign w_rem_sh = {r_rem, r_quo[DVD_W-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_iter <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
      r_iter <= ITER_W'(DVD_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (w_diff[DVS_W]) begin
        r_rem <= w_rem_sh[DVS_W-1:0];
        r_quo <= {r_quo[DVD_W-2:0], 1'b0};
      end else begin
        r_rem <= w_diff[DVS_W-1:0];
        r_quo <= {r_quo[DVD_W-2:0], 1'b1};
      end
      r_iter <= r_iter - ITER_W'(1);
      r_busy <= (r_iter != ITER_W'(1));
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_iter == ITER_W'(1));
  assign o_quot = r_quo[Q_W-1:0];

endmodule

// File: rtl/cluster_centroid_engine.sv
// Per-cluster coordinate accumulation over a frame, then serial mean per
// cluster emitted in label order over a valid/ready handshake.
module cluster_centroid_engine
  import cluster_centroid_pkg::*;
#(
  parameter int NUM_CLUSTERS = DEF_NUM_CLUSTERS,
  parameter int LABEL_W      = $clog2(NUM_CLUSTERS),
  parameter int COORD_W      = DEF_COORD_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int SUM_W        = COORD_W + CNT_W
) (
  input  logic               Center_clk,
  input  logic               Center_rst,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [LABEL_W-1:0] pt_label,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  input  logic               pt_last,
  output logic               ctr_valid,
  input  logic               ctr_ready,
  output logic [LABEL_W-1:0] ctr_label,
  output logic [COORD_W-1:0] ctr_x,
  output logic [COORD_W-1:0] ctr_y,
  output logic [CNT_W-1:0]   ctr_count,
  output logic               ctr_empty,
  output logic               frame_done,
  output logic               err_label,
  output logic               err_sat
);

  state_e                              r_state, w_state_nxt;
  logic [LABEL_W-1:0]                  r_k, w_k_nxt;
  logic                                r_live, r_frame_done, r_err_label, r_err_sat;
  logic [NUM_CLUSTERS-1:0][SUM_W-1:0]  r_sum_x, r_sum_y;
  logic [NUM_CLUSTERS-1:0][CNT_W-1:0]  r_cnt;
  logic [NUM_CLUSTERS-1:0]             w_hit, w_full;
  logic [(1<<LABEL_W)-1:0]             w_lbl_map;
  logic                                w_pt_acc, w_lbl_ok, w_start, w_clear, w_fin;
  logic                                w_emit, w_empty, w_busy, w_done;
  logic                                w_busy_x, w_busy_y, w_done_x, w_done_y;
  logic [SUM_W-1:0]                    w_sx_k, w_sy_k;
  logic [CNT_W-1:0]                    w_cnt_k;
  logic [COORD_W-1:0]                  w_qx, w_qy;

  // Table of in-range labels; avoids a compare that is constant when K is a power of two.
  for (genvar g = 0; g < (1 << LABEL_W); g++) begin : g_lmap
    assign w_lbl_map[g] = (g < NUM_CLUSTERS);
  end

  assign w_lbl_ok = w_lbl_map[pt_label];
  assign pt_ready = r_live && (r_state == ST_ACCUM);
  assign w_pt_acc = pt_valid && pt_ready;

  for (genvar g = 0; g < NUM_CLUSTERS; g++) begin : g_acc
    assign w_hit[g]  = w_pt_acc && (pt_label == LABEL_W'(g));
    assign w_full[g] = &r_cnt[g];

    always_ff @(posedge Center_clk or negedge Center_rst) begin
      if (!Center_rst) begin
        r_sum_x[g] <= '0;
        r_sum_y[g] <= '0;
        r_cnt[g]   <= '0;
      end else if (w_clear && (r_k == LABEL_W'(g))) begin
        r_sum_x[g] <= '0;
        r_sum_y[g] <= '0;
        r_cnt[g]   <= '0;
      end else if (w_hit[g] && !w_full[g]) begin
        r_sum_x[g] <= r_sum_x[g] + SUM_W'(pt_x);
        r_sum_y[g] <= r_sum_y[g] + SUM_W'(pt_y);
        r_cnt[g]   <= r_cnt[g] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_sx_k  = '0;
    w_sy_k  = '0;
    w_cnt_k = '0;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      if (r_k == LABEL_W'(i)) begin
        w_sx_k  = r_sum_x[i];
        w_sy_k  = r_sum_y[i];
        w_cnt_k = r_cnt[i];
      end
    end
  end

  center_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(COORD_W)) u_div_x (
    .clk(Center_clk), .rst_n(Center_rst), .i_start(w_start),
    .i_dividend(w_sx_k), .i_divisor(w_cnt_k),
    .o_busy(w_busy_x), .o_done(w_done_x), .o_quot(w_qx)
  );

  center_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(COORD_W)) u_div_y (
    .clk(Center_clk), .rst_n(Center_rst), .i_start(w_start),
    .i_dividend(w_sy_k), .i_divisor(w_cnt_k),
    .o_busy(w_busy_y), .o_done(w_done_y), .o_quot(w_qy)
  );

  assign w_busy  = w_busy_x | w_busy_y;
  assign w_done  = w_done_x & w_done_y;
  assign w_empty = (w_cnt_k == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_start     = 1'b0;
    w_clear     = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      ST_ACCUM: begin
        if (w_pt_acc && pt_last) begin
          w_state_nxt = ST_DIVIDE;
          w_k_nxt     = '0;
        end
      end
      ST_DIVIDE: begin
        // Empty cluster skips the divider entirely; its mean is forced to zero.
        if (w_empty || w_done) w_state_nxt = ST_EMIT;
        else if (!w_busy)      w_start     = 1'b1;
      end
      ST_EMIT: begin
        if (ctr_ready) begin
          w_clear = 1'b1;
          if (r_k == LABEL_W'(NUM_CLUSTERS - 1)) begin
            w_fin       = 1'b1;
            w_state_nxt = ST_ACCUM;
          end else begin
            w_k_nxt     = r_k + LABEL_W'(1);
            w_state_nxt = ST_DIVIDE;
          end
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge Center_clk or negedge Center_rst) begin
    if (!Center_rst) begin
      r_state      <= ST_ACCUM;
      r_k          <= '0;
      r_live       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_label  <= 1'b0;
      r_err_sat    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_live       <= 1'b1;
      r_frame_done <= w_fin;
      if (w_pt_acc && !w_lbl_ok) r_err_label <= 1'b1;
      if (|(w_hit & w_full))     r_err_sat   <= 1'b1;
    end
  end

  assign w_emit     = (r_state == ST_EMIT);
  assign ctr_valid  = w_emit;
  assign ctr_label  = w_emit ? r_k : '0;
  assign ctr_x      = (w_emit && !w_empty) ? w_qx : '0;
  assign ctr_y      = (w_emit && !w_empty) ? w_qy : '0;
  assign ctr_count  = w_emit ? w_cnt_k : '0;
  assign ctr_empty  = w_emit && w_empty;
  assign frame_done = r_frame_done;
  assign err_label  = r_err_label;
  assign err_sat    = r_err_sat;

endmodule

// File: tb/tb_cluster_centroid_engine.sv
// Directed + randomized bench with a per-cluster sum/count reference model.
module tb_cluster_centroid_engine;

  localparam int N    = 8;
  localparam int LW   = 4;
  localparam int CW   = 9;
  localparam int NW   = 3;
  localparam int SW   = CW + NW;
  localparam int CMAX = (1 << NW) - 1;

  logic          Center_clk, Center_rst;
  logic          pt_valid, pt_ready, pt_last;
  logic [LW-1:0] pt_label;
  logic [CW-1:0] pt_x, pt_y;
  logic          ctr_valid, ctr_ready, ctr_empty, frame_done, err_label, err_sat;
  logic [LW-1:0] ctr_label;
  logic [CW-1:0] ctr_x, ctr_y;
  logic [NW-1:0] ctr_count;

  int total = 0;
  int bad   = 0;
  int m_sx[N], m_sy[N], m_cnt[N];
  bit m_err_lbl, m_err_sat;

  cluster_centroid_engine #(.NUM_CLUSTERS(N), .LABEL_W(LW), .COORD_W(CW), .CNT_W(NW)) dut (
    .Center_clk(Center_clk), .Center_rst(Center_rst),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_label(pt_label),
    .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last),
    .ctr_valid(ctr_valid), .ctr_ready(ctr_ready), .ctr_label(ctr_label),
    .ctr_x(ctr_x), .ctr_y(ctr_y), .ctr_count(ctr_count), .ctr_empty(ctr_empty),
    .frame_done(frame_done), .err_label(err_label), .err_sat(err_sat)
  );

  initial Center_clk = 1'b0;
  always #5 Center_clk = ~Center_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic send_point(input int lbl, input int x, input int y, input bit last);
    pt_valid = 1'b1;
    pt_label = LW'(lbl);
    pt_x     = CW'(x);
    pt_y     = CW'(y);
    pt_last  = last;
    chk("pt_ready_accum", pt_ready, 1);
    @(posedge Center_clk); #1;
    pt_valid = 1'b0;
    pt_last  = 1'b0;
    if (lbl >= N)               m_err_lbl = 1'b1;
    else if (m_cnt[lbl] == CMAX) m_err_sat = 1'b1;
    else begin
      m_sx[lbl] += x; m_sy[lbl] += y; m_cnt[lbl] += 1;
    end
  endtask

  task automatic check_ctr(input int k);
    int ex, ey;
    ex = (m_cnt[k] == 0) ? 0 : m_sx[k] / m_cnt[k];
    ey = (m_cnt[k] == 0) ? 0 : m_sy[k] / m_cnt[k];
    chk("ctr_valid", ctr_valid, 1);
    chk("ctr_label", ctr_label, k);
    chk("ctr_x", ctr_x, ex);
    chk("ctr_y", ctr_y, ey);
    chk("ctr_count", ctr_count, m_cnt[k]);
    chk("ctr_empty", ctr_empty, (m_cnt[k] == 0) ? 1 : 0);
  endtask

  // Call right after the pt_last handshake; consumes all N centroids.
  task automatic collect_frame(input int stall_k, input int stall_n);
    int edges;
    for (int k = 0; k < N; k++) begin
      edges = 0;
      while (ctr_valid !== 1'b1 && edges < 100) begin
        chk("pt_ready_busy", pt_ready, 0);
        @(posedge Center_clk); #1;
        edges++;
      end
      chk("latency", edges, (m_cnt[k] == 0) ? 1 : SW + 1);
      check_ctr(k);
      if (k == stall_k) begin
        ctr_ready = 1'b0;
        pt_valid  = 1'b1;
        repeat (stall_n) begin
          pt_label = LW'($urandom_range(0, N - 1));
          pt_x     = CW'($urandom_range(0, 511));
          pt_y     = CW'($urandom_range(0, 511));
          @(posedge Center_clk); #1;
          check_ctr(k);
          chk("pt_ready_stall", pt_ready, 0);
        end
        pt_valid  = 1'b0;
        ctr_ready = 1'b1;
      end
      @(posedge Center_clk); #1;
      m_sx[k] = 0; m_sy[k] = 0; m_cnt[k] = 0;
      chk("frame_done", frame_done, (k == N - 1) ? 1 : 0);
    end
    chk("pt_ready_after", pt_ready, 1);
    chk("ctr_valid_after", ctr_valid, 0);
    chk("err_label", err_label, m_err_lbl);
    chk("err_sat", err_sat, m_err_sat);
    @(posedge Center_clk); #1;
    chk("frame_done_pulse", frame_done, 0);
  endtask

  initial begin
    int edges, npts, lbl, spur;
    Center_rst = 1'b0;
    pt_valid = 1'b0; pt_last = 1'b0; pt_label = '0; pt_x = '0; pt_y = '0;
    ctr_ready = 1'b1;
    m_err_lbl = 1'b0; m_err_sat = 1'b0;
    model_clear();
    #1;
    chk("rst_pt_ready", pt_ready, 0);
    chk("rst_ctr_valid", ctr_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_label", err_label, 0);
    chk("rst_err_sat", err_sat, 0);
    chk("rst_ctr_x", ctr_x, 0);
    chk("rst_ctr_count", ctr_count, 0);
    repeat (3) @(posedge Center_clk);
    #3 Center_rst = 1'b1;
    @(posedge Center_clk); #1;
    chk("first_pt_ready", pt_ready, 1);

    // Label 5 frame: mean (60,131) over 5 points, all others empty.
    send_point(5, 53, 17, 0);  send_point(5, 14, 245, 0); send_point(5, 107, 43, 0);
    send_point(5, 64, 8, 0);   send_point(5, 62, 345, 1);
    collect_frame(-1, 0);

    // Same frame, consumer stalls 10 cycles on label 5.
    send_point(5, 53, 17, 0);  send_point(5, 14, 245, 0); send_point(5, 107, 43, 0);
    send_point(5, 64, 8, 0);   send_point(5, 62, 345, 1);
    collect_frame(5, 10);

    // Following frame: label 0 only; label 5 must read empty.
    send_point(0, 10, 20, 0);  send_point(0, 11, 21, 1);
    collect_frame(-1, 0);

    // Out-of-range label is dropped and flagged.
    send_point(2, 100, 200, 0); send_point(9, 500, 500, 0); send_point(2, 50, 60, 1);
    collect_frame(-1, 0);

    // Eight points to label 1 with a 3-bit counter: 8th dropped but still ends the frame.
    for (int i = 0; i < 8; i++) send_point(1, 10 + i * 30, 500 - i * 20, i == 7);
    collect_frame(-1, 0);

    // Randomized frames, including occasional bad labels and consumer stalls.
    for (int f = 0; f < 6; f++) begin
      npts = $urandom_range(1, 25);
      for (int p = 0; p < npts; p++) begin
        lbl = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
        send_point(lbl, $urandom_range(0, 511), $urandom_range(0, 511), p == npts - 1);
      end
      collect_frame($urandom_range(0, 7), $urandom_range(0, 4));
    end

    // Reset in the middle of label 3's division.
    send_point(3, 100, 200, 0); send_point(3, 300, 40, 1);
    edges = 0;
    while (!(ctr_valid === 1'b1 && ctr_label === LW'(2)) && edges < 100) begin
      @(posedge Center_clk); #1;
      edges++;
    end
    chk("reach_label2", ctr_label, 2);
    @(posedge Center_clk); #1;
    repeat (3) @(posedge Center_clk);
    #1;
    chk("mid_divide_valid", ctr_valid, 0);
    Center_rst = 1'b0;
    #2;
    chk("abort_ctr_valid", ctr_valid, 0);
    chk("abort_pt_ready", pt_ready, 0);
    chk("abort_err_label", err_label, 0);
    chk("abort_err_sat", err_sat, 0);
    model_clear();
    m_err_lbl = 1'b0; m_err_sat = 1'b0;
    @(posedge Center_clk); #3;
    Center_rst = 1'b1;
    @(posedge Center_clk); #1;
    chk("rerelease_pt_ready", pt_ready, 1);
    spur = 0;
    repeat (30) begin
      @(posedge Center_clk); #1;
      if (ctr_valid !== 1'b0 || frame_done !== 1'b0) spur++;
    end
    chk("no_spurious_out", spur, 0);
    send_point(6, 40, 80, 0); send_point(6, 41, 81, 1);
    collect_frame(-1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cluster_centroid_engine.md
# cluster_centroid_engine

Parametrised successor to the single-cluster centre calculator in the K-means datapath. It accepts a stream of labelled points from the assignment stage and keeps per-cluster coordinate sums and counts. At frame end it computes each cluster's mean with a serial divider and emits one centroid per cluster, in label order, to the centre-update stage over a valid/ready handshake.

## Interface
- NUM_CLUSTERS, 8, number of clusters K (≥2)
- LABEL_W, $clog2(NUM_CLUSTERS), label width
- COORD_W, 9, coordinate width (unsigned)
- CNT_W, 16, per-cluster point counter width
- SUM_W, COORD_W+CNT_W, accumulator width
- Center_clk  in  1  single clock, rising edge
- Center_rst  in  1  asynchronous, active-low reset
- pt_valid  in  1  point present
- pt_ready  out  1  engine accepts point
- pt_label  in  LABEL_W  cluster index of point
- pt_x, pt_y  in  COORD_W  point coordinates
- pt_last  in  1  point is last of frame
- ctr_valid  out  1  centroid present
- ctr_ready  in  1  consumer accepts centroid
- ctr_label  out  LABEL_W  cluster index of centroid
- ctr_x, ctr_y  out  COORD_W  centroid (truncated mean)
- ctr_count  out  CNT_W  points in cluster this frame
- ctr_empty  out  1  cluster received zero points
- frame_done  out  1  one-cycle pulse after last centroid accepted
- err_label  out  1  sticky: label ≥ NUM_CLUSTERS seen
- err_sat  out  1  sticky: a counter saturated

## Operation
- States: ACCUM, DIVIDE, EMIT.
- ACCUM: pt_ready=1. On pt_valid&pt_ready:
  - sum_x[l]+=pt_x, sum_y[l]+=pt_y, cnt[l]+=1.
  - Label ≥ NUM_CLUSTERS: point dropped, err_label set.
  - cnt[l] at all-ones: point dropped, err_sat set.
  - pt_last accepted: k←0, go to DIVIDE. The last point itself is accumulated.
- DIVIDE:
  - cnt[k]==0: next edge → EMIT, with ctr_x=ctr_y=0 and ctr_empty=1.
  - Otherwise: load edge, then SUM_W restoring-division iterations on sum_x/cnt and sum_y/cnt in parallel, then → EMIT.
  - Quotient truncates toward zero. Its low COORD_W bits are exact, since mean ≤ max coordinate.
- EMIT:
  - ctr_valid=1; all ctr_* outputs stay stable until ctr_ready.
  - On handshake: clear sum_x[k], sum_y[k], cnt[k].
  - If k==NUM_CLUSTERS-1: pulse frame_done and go to ACCUM. Else k+1 → DIVIDE.
- pt_ready=0 in DIVIDE and EMIT; upstream stalls.
- Error flags are cleared only by reset.

## Timing
- Reset values: state ACCUM, all sums/counts 0, pt_ready=0 during reset and 1 on the first edge after release. All other outputs 0.
- Throughput in ACCUM: one point per cycle.
- Non-empty cluster: ctr_valid rises SUM_W+1 edges after the edge entering DIVIDE. Entry happens on the pt_last handshake edge or the previous ctr handshake edge. Default latency is 26 edges.
- Empty cluster: ctr_valid rises 1 edge after DIVIDE entry.
- frame_done is high in the cycle after the final ctr handshake, coincident with pt_ready=1.
- pt_valid without pt_last in the last accepted point: the engine stays in ACCUM indefinitely (no timeout).
- pt_last on a dropped point (bad label or saturated) still ends the frame.
- ctr_ready held high: back-to-back clusters each cost DIVIDE + 1 EMIT cycle.
- Reset asserted mid-DIVIDE/EMIT aborts immediately. The partial frame is lost and no frame_done is issued.

## Structure
- Package cluster_centroid_pkg holds:
  - state encoding (ACCUM/DIVIDE/EMIT)
  - default parameter constants (NUM_CLUSTERS, COORD_W, CNT_W)
- Sub-module center_divider: unsigned serial restoring divider (SUM_W dividend, CNT_W divisor, start/done). Instantiated twice (x, y) and started together.
- Accumulators are register arrays indexed by label. No RAM.

## Test plan
- Label 5, points (53,17),(14,245),(107,43),(64,8),(62,345), last on the 5th → label 5: ctr_x=60, ctr_y=131, count=5. Labels 0–4 and 6–7: ctr_empty=1, x=y=0. frame_done after label 7.
- Same frame with ctr_ready low for 10 cycles at label 5 → outputs stable, pt_ready=0 throughout, no data lost.
- Two consecutive frames (second: label 0 with (10,20),(11,21)) → frame 2 label 0 gives (10,20), count=2. Label 5 is empty, confirming the clear on emit.
- pt_label=9 with NUM_CLUSTERS=8, then a valid point with pt_last → err_label=1, bad point excluded from all sums.
- CNT_W=3: eight points to label 1 → err_sat=1, count=7, mean over the first 7 only.
- Reset asserted during DIVIDE of label 3 → after release all counts read 0 in the next frame, no spurious ctr_valid.
